// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display stage.
// Holds the conversion FSM state, page encoding and active-low segment
// patterns (seg[0]=a ... seg[6]=g).
package alu_disp_pkg;

  localparam int unsigned SCAN_DIGITS  = 4;
  localparam int unsigned CONV_BITS    = 8;
  localparam int unsigned BCD_BITS     = 12;
  localparam int unsigned SEG_BITS     = 7;
  localparam int unsigned SCRATCH_BITS = BCD_BITS + CONV_BITS;
  localparam int unsigned STEP_BITS    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } convStateT;

  typedef enum logic [1:0] {
    PAGE_A = 2'd0,
    PAGE_B = 2'd1,
    PAGE_Y = 2'd2
  } pageT;

  localparam logic [SEG_BITS-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_BITS-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_BITS-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_BITS-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_BITS-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_BITS-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_BITS-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_BITS-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_BITS-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_BITS-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_BITS-1:0] SEG_LTR_A = 7'b0001000;
  localparam logic [SEG_BITS-1:0] SEG_LTR_B = 7'b0000011;
  localparam logic [SEG_BITS-1:0] SEG_LTR_Y = 7'b0010001;
  localparam logic [SEG_BITS-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_BITS-1:0] SEG_MINUS = 7'b0111111;

  // Decimal digit to segment pattern; non-decimal codes show blank.
  function automatic logic [SEG_BITS-1:0] segOfDigit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_display_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, 8 shift steps then one commit cycle.
// Ports: clock, reset (async active-low), start (capture value, restarts
// any conversion in flight), value[7:0]; busy (SHIFT or COMMIT), done (high
// during the COMMIT cycle), bcd[11:0] (last committed hundreds/tens/ones).
module bin2bcd_seq
  import alu_disp_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CONV_BITS-1:0] value,
  output logic                 busy,
  output logic                 done,
  output logic [BCD_BITS-1:0]  bcd
);

  convStateT                state, stateNext;
  logic [STEP_BITS-1:0]     stepCnt, stepCntNext;
  logic [SCRATCH_BITS-1:0]  scratch, scratchNext;
  logic [BCD_BITS-1:0]      bcdNext;
  logic                     busyNext, doneNext;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SCRATCH_BITS-1:0] ddStep(input logic [SCRATCH_BITS-1:0] s);
    logic [SCRATCH_BITS-1:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[CONV_BITS + 4*i +: 4] >= 4'd5)
        t[CONV_BITS + 4*i +: 4] = t[CONV_BITS + 4*i +: 4] + 4'd3;
    end
    return {t[SCRATCH_BITS-2:0], 1'b0};
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state; start always wins so a retrigger aborts a pending commit
  always_comb begin
    stateNext = state;
    if (start) begin
      stateNext = SHIFT;
    end else begin
      case (state)
        SHIFT:   if (stepCnt == STEP_BITS'(7)) stateNext = COMMIT;
        COMMIT:  stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Datapath and status next values
  always_comb begin
    stepCntNext = stepCnt;
    scratchNext = scratch;
    bcdNext     = bcd;
    if (start) begin
      stepCntNext = '0;
      scratchNext = {BCD_BITS'(0), value};
    end else begin
      case (state)
        SHIFT: begin
          stepCntNext = stepCnt + STEP_BITS'(1);
          scratchNext = ddStep(scratch);
        end
        COMMIT:  bcdNext = scratch[SCRATCH_BITS-1:CONV_BITS];
        default: ;
      endcase
    end
    busyNext = (stateNext != IDLE);
    doneNext = (stateNext == COMMIT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stepCnt <= '0;
      scratch <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      stepCnt <= stepCntNext;
      scratch <= scratchNext;
      bcd     <= bcdNext;
      busy    <= busyNext;
      done    <= doneNext;
    end
  end

endmodule

// File: rtl/alu_result_display.sv
// alu_result_display: pages through A/B/Y, converts the selected byte to
// decimal and scans it onto a 4-digit active-low seven-segment display.
// Ports: clock, reset (async active-low), scan_tick, a/b/y[7:0], load,
// page_next; an[3:0], seg[6:0], busy, page[1:0].
// Build option: define SIGNED_DISPLAY_EN to show bytes as two's complement
// with a '-' in place of the page letter for negative values.
module alu_result_display
  import alu_disp_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   scan_tick,
  input  logic [CONV_BITS-1:0]   a,
  input  logic [CONV_BITS-1:0]   b,
  input  logic [CONV_BITS-1:0]   y,
  input  logic                   load,
  input  logic                   page_next,
  output logic [SCAN_DIGITS-1:0] an,
  output logic [SEG_BITS-1:0]    seg,
  output logic                   busy,
  output logic [1:0]             page
);

  logic                   req;
  pageT                   pageQ, pageNxt, pendPage, dispPage;
  logic [CONV_BITS-1:0]   selByte, convValue;
  logic                   convDone, commit;
  logic [BCD_BITS-1:0]    bcd;
  logic [1:0]             scanIdx;
  logic [SCAN_DIGITS-1:0] anNext;
  logic [SEG_BITS-1:0]    segNext, letterSeg;

  assign req    = load | page_next;
  // A request in the COMMIT cycle aborts the commit inside the converter.
  assign commit = convDone & ~req;
  assign page   = pageQ;

  // Page advance happens before capture so the new page's byte is converted
  always_comb begin
    pageNxt = pageQ;
    if (page_next) begin
      case (pageQ)
        PAGE_A:  pageNxt = PAGE_B;
        PAGE_B:  pageNxt = PAGE_Y;
        default: pageNxt = PAGE_A;
      endcase
    end
    case (pageNxt)
      PAGE_A:  selByte = a;
      PAGE_B:  selByte = b;
      default: selByte = y;
    endcase
  end

`ifdef SIGNED_DISPLAY_EN
  logic pendSign, signFlag;
  assign convValue = selByte[CONV_BITS-1] ? (~selByte + CONV_BITS'(1)) : selByte;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pendSign <= 1'b0;
      signFlag <= 1'b0;
    end else begin
      if (req)    pendSign <= selByte[CONV_BITS-1];
      if (commit) signFlag <= pendSign;
    end
  end
`else
  assign convValue = selByte;
`endif

  bin2bcd_seq uConv (
    .clock (clock),
    .reset (reset),
    .start (req),
    .value (convValue),
    .busy  (busy),
    .done  (convDone),
    .bcd   (bcd)
  );

  // Page letter is latched with the digits so the display stays consistent
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pageQ    <= PAGE_A;
      pendPage <= PAGE_A;
      dispPage <= PAGE_A;
      scanIdx  <= 2'd0;
    end else begin
      pageQ <= pageNxt;
      if (req)       pendPage <= pageNxt;
      if (commit)    dispPage <= pendPage;
      if (scan_tick) scanIdx  <= scanIdx + 2'd1;
    end
  end

  // Digit selection with leading-zero blanking
  always_comb begin
    case (dispPage)
      PAGE_A:  letterSeg = SEG_LTR_A;
      PAGE_B:  letterSeg = SEG_LTR_B;
      default: letterSeg = SEG_LTR_Y;
    endcase
`ifdef SIGNED_DISPLAY_EN
    if (signFlag) letterSeg = SEG_MINUS;
`endif
    anNext = ~(SCAN_DIGITS'(1) << scanIdx);
    case (scanIdx)
      2'd0:    segNext = segOfDigit(bcd[3:0]);
      2'd1:    segNext = (bcd[11:4] == 8'd0) ? SEG_BLANK : segOfDigit(bcd[7:4]);
      2'd2:    segNext = (bcd[11:8] == 4'd0) ? SEG_BLANK : segOfDigit(bcd[11:8]);
      default: segNext = letterSeg;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1110;
      seg <= SEG_0;
    end else begin
      an  <= anNext;
      seg <= segNext;
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display: paging, conversion latency,
// retrigger, blanking, wrap and asynchronous reset.
module tb_alu_result_display;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       scan_tick = 1'b0;
  logic [7:0] a = 8'd0, b = 8'd0, y = 8'd0;
  logic       load = 1'b0, page_next = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       busy;
  logic [1:0] page;

  int checks = 0;
  int errors = 0;
  logic [1:0] tbIdx = 2'd0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, SBL = 7'b1111111;
  localparam logic [6:0] LA = 7'b0001000, LB = 7'b0000011, LY = 7'b0010001;
  localparam logic [6:0] SMI = 7'b0111111;

  alu_result_display dut (
    .clock     (clock),
    .reset     (reset),
    .scan_tick (scan_tick),
    .a         (a),
    .b         (b),
    .y         (y),
    .load      (load),
    .page_next (page_next),
    .an        (an),
    .seg       (seg),
    .busy      (busy),
    .page      (page)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic doLoad, input logic doNext);
    load = doLoad;
    page_next = doNext;
    cyc();
    load = 1'b0;
    page_next = 1'b0;
  endtask

  // Counts cycles busy stays high (bounded).
  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      cyc();
    end
  endtask

  // Steps the scan through all four digits, returns segs by index and an order.
  task automatic readSegs(output logic [27:0] segs, output bit anOk);
    anOk = 1'b1;
    segs = '0;
    for (int s = 0; s < 4; s++) begin
      scan_tick = 1'b1;
      cyc();
      scan_tick = 1'b0;
      cyc();
      tbIdx = tbIdx + 2'd1;
      if (an !== ~(4'b0001 << tbIdx)) anOk = 1'b0;
      segs[7*tbIdx +: 7] = seg;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc();
    @(negedge clock);
    reset = 1'b1;
    tbIdx = 2'd0;
    cyc();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b want 1110", an); end
    checks++; if (seg !== S0) begin errors++; $display("FAIL reset_seg got %b want %b", seg, S0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (page !== 2'd0) begin errors++; $display("FAIL reset_page got %0d want 0", page); end
  endtask

  task automatic test_y255();
    int n;
    logic [27:0] s;
    bit ok;
    y = 8'd255;
    pulse(1'b0, 1'b1);
    countBusy(n);
    pulse(1'b0, 1'b1);
    countBusy(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL y255_busy_cycles got %0d want 9", n); end
    checks++; if (page !== 2'd2) begin errors++; $display("FAIL y255_page got %0d want 2", page); end
    readSegs(s, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL y255_an_order got %b want 1", ok); end
    checks++; if (s[6:0] !== S5) begin errors++; $display("FAIL y255_ones got %b want %b", s[6:0], S5); end
    checks++; if (s[13:7] !== S5) begin errors++; $display("FAIL y255_tens got %b want %b", s[13:7], S5); end
    checks++; if (s[20:14] !== S2) begin errors++; $display("FAIL y255_hund got %b want %b", s[20:14], S2); end
    checks++; if (s[27:21] !== LY) begin errors++; $display("FAIL y255_letter got %b want %b", s[27:21], LY); end
  endtask

  task automatic test_wrap_a7();
    int n;
    logic [27:0] s;
    bit ok;
    a = 8'd7;
    pulse(1'b1, 1'b1);
    countBusy(n);
    checks++; if (page !== 2'd0) begin errors++; $display("FAIL wrap_page got %0d want 0", page); end
    readSegs(s, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_an_order got %b want 1", ok); end
    checks++; if (s[6:0] !== S7) begin errors++; $display("FAIL wrap_ones got %b want %b", s[6:0], S7); end
    checks++; if (s[13:7] !== SBL) begin errors++; $display("FAIL wrap_tens got %b want %b", s[13:7], SBL); end
    checks++; if (s[20:14] !== SBL) begin errors++; $display("FAIL wrap_hund got %b want %b", s[20:14], SBL); end
    checks++; if (s[27:21] !== LA) begin errors++; $display("FAIL wrap_letter got %b want %b", s[27:21], LA); end
  endtask

  task automatic test_retrigger();
    int n;
    int changed;
    logic [6:0] seg0;
    logic [27:0] s;
    bit ok;
    changed = 0;
    seg0 = seg;
    b = 8'd100;
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (seg !== seg0) changed++;
      cyc();
    end
    b = 8'd42;
    pulse(1'b1, 1'b0);
    n = 0;
    while (busy && n < 40) begin
      if (seg !== seg0) changed++;
      n++;
      cyc();
    end
    checks++; if (n !== 9) begin errors++; $display("FAIL retrig_busy_cycles got %0d want 9", n); end
    checks++; if (changed !== 0) begin errors++; $display("FAIL retrig_no_early_commit got %0d changes want 0", changed); end
    checks++; if (page !== 2'd1) begin errors++; $display("FAIL retrig_page got %0d want 1", page); end
    readSegs(s, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL retrig_an_order got %b want 1", ok); end
    checks++; if (s[6:0] !== S2) begin errors++; $display("FAIL retrig_ones got %b want %b", s[6:0], S2); end
    checks++; if (s[13:7] !== S4) begin errors++; $display("FAIL retrig_tens got %b want %b", s[13:7], S4); end
    checks++; if (s[20:14] !== SBL) begin errors++; $display("FAIL retrig_hund got %b want %b", s[20:14], SBL); end
    checks++; if (s[27:21] !== LB) begin errors++; $display("FAIL retrig_letter got %b want %b", s[27:21], LB); end
  endtask

  task automatic test_reset_mid();
    logic [27:0] s;
    bit ok;
    b = 8'd200;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    reset = 1'b0;
    #1;
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rstmid_an got %b want 1110", an); end
    checks++; if (seg !== S0) begin errors++; $display("FAIL rstmid_seg got %b want %b", seg, S0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(negedge clock);
    reset = 1'b1;
    tbIdx = 2'd0;
    for (int i = 0; i < 15; i++) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b want 0", busy); end
    checks++; if (page !== 2'd0) begin errors++; $display("FAIL rstmid_page got %0d want 0", page); end
    readSegs(s, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_an_order got %b want 1", ok); end
    checks++; if (s[6:0] !== S0) begin errors++; $display("FAIL rstmid_ones got %b want %b", s[6:0], S0); end
    checks++; if (s[20:7] !== {SBL, SBL}) begin errors++; $display("FAIL rstmid_upper got %b want all ones", s[20:7]); end
    checks++; if (s[27:21] !== LA) begin errors++; $display("FAIL rstmid_letter got %b want %b", s[27:21], LA); end
  endtask

`ifdef SIGNED_DISPLAY_EN
  task automatic test_signed();
    int n;
    logic [27:0] s;
    bit ok;
    a = 8'h80;
    pulse(1'b1, 1'b0);
    countBusy(n);
    readSegs(s, ok);
    checks++; if (s !== {SMI, S1, S2, S8}) begin errors++; $display("FAIL signed_m128 got %h want %h", s, {SMI, S1, S2, S8}); end
    a = 8'hFF;
    pulse(1'b1, 1'b0);
    countBusy(n);
    readSegs(s, ok);
    checks++; if (s !== {SMI, SBL, SBL, S1}) begin errors++; $display("FAIL signed_m1 got %h want %h", s, {SMI, SBL, SBL, S1}); end
    a = 8'h7F;
    pulse(1'b1, 1'b0);
    countBusy(n);
    readSegs(s, ok);
    checks++; if (s !== {LA, S1, S2, S7}) begin errors++; $display("FAIL signed_p127 got %h want %h", s, {LA, S1, S2, S7}); end
  endtask
`endif

  initial begin
    test_reset();
    test_y255();
    test_wrap_a7();
    test_retrigger();
    test_reset_mid();
`ifdef SIGNED_DISPLAY_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
